// File: rtl/keypad_pkg.sv
// Shared types, key map and column-decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } kp_state_t;

    typedef enum logic [1:0] {
        SCAN_NONE   = 2'd0,
        SCAN_SINGLE = 2'd1,
        SCAN_MULTI  = 2'd2
    } scan_result_t;

    localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Number of pulled-low (pressed) columns in an active-low column word.
    function automatic logic [2:0] count_active(input logic [3:0] cols_n);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_COLS; i++) begin
            n = n + {2'b00, ~cols_n[i]};
        end
        return n;
    endfunction

    function automatic logic [1:0] first_active(input logic [3:0] cols_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (!cols_n[i]) begin
                idx = 2'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_row_scan.sv
// Row driver, column synchronizer and per-scan classification (NONE/SINGLE/MULTI).
module keypad_row_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   i_cols,
    output logic [3:0]   o_rows,
    output logic         o_scan_done,
    output scan_result_t o_result,
    output logic [3:0]   o_code
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_row_idx;
    logic [3:0]    r_rows;
    logic [3:0]    r_cols_meta;
    logic [3:0]    r_cols_sync;
    logic [1:0]    r_acc_cnt;
    logic [3:0]    r_acc_code;

    logic          w_tick;
    logic [1:0]    w_idx_nxt;
    logic [2:0]    w_row_hits;
    logic [1:0]    w_row_col;
    logic [2:0]    w_tot;
    logic [1:0]    w_tot_sat;
    logic [3:0]    w_code_nxt;

    assign w_tick     = (r_presc == PW'(SCAN_DIV - 1));
    assign w_idx_nxt  = r_row_idx + 2'd1;
    assign w_row_hits = count_active(r_cols_sync);
    assign w_row_col  = first_active(r_cols_sync);
    assign w_tot      = {1'b0, r_acc_cnt} + w_row_hits;

    // Merge the current row's sample into the running per-scan tally.
    always_comb begin
        w_tot_sat  = (w_tot >= 3'd2) ? 2'd2 : w_tot[1:0];
        w_code_nxt = r_acc_code;
        if (w_row_hits == 3'd1) begin
            w_code_nxt = KEY_MAP[r_row_idx][w_row_col];
        end else begin
            w_code_nxt = r_acc_code;
        end
    end

    // Classification of the completed scan, valid only while o_scan_done is high.
    always_comb begin
        o_scan_done = w_tick && (r_row_idx == 2'd3);
        o_code      = w_code_nxt;
        case (w_tot_sat)
            2'd0:    o_result = SCAN_NONE;
            2'd1:    o_result = SCAN_SINGLE;
            default: o_result = SCAN_MULTI;
        endcase
    end

    // Two-flop synchronizer; idle value is all columns released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cols_meta <= 4'hF;
            r_cols_sync <= 4'hF;
        end else begin
            r_cols_meta <= i_cols;
            r_cols_sync <= r_cols_meta;
        end
    end

    // Prescaler, row sequencing and scan accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc    <= '0;
            r_row_idx  <= 2'd0;
            r_rows     <= 4'b1110;
            r_acc_cnt  <= 2'd0;
            r_acc_code <= 4'h0;
        end else if (w_tick) begin
            r_presc   <= '0;
            r_row_idx <= w_idx_nxt;
            r_rows    <= ~(4'b0001 << w_idx_nxt);
            if (r_row_idx == 2'd3) begin
                r_acc_cnt  <= 2'd0;
                r_acc_code <= 4'h0;
            end else begin
                r_acc_cnt  <= w_tot_sat;
                r_acc_code <= w_code_nxt;
            end
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign o_rows = r_rows;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: debounce FSM, key strobe and 4-nibble history word.
// Optional auto-repeat while held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  cols,
    output logic [3:0]  rows,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] data
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    kp_state_t    r_state;
    kp_state_t    w_next_state;
    logic [3:0]   r_cand;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_rcnt;
    logic [3:0]   r_key_code;
    logic         r_key_valid;
    logic         r_key_held;
    logic [15:0]  r_data;

    logic         w_scan_done;
    scan_result_t w_result;
    logic [3:0]   w_code;
    logic [3:0]   w_rows;
    logic [CW-1:0] w_cnt_inc;
    logic [CW-1:0] w_rcnt_inc;
    logic         w_key_match;
    logic         w_rep_fire;
    logic         w_accept;
    logic [3:0]   w_accept_code;

    keypad_row_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_row_scan (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cols      (cols),
        .o_rows      (w_rows),
        .o_scan_done (w_scan_done),
        .o_result    (w_result),
        .o_code      (w_code)
    );

    assign w_cnt_inc   = r_cnt + CW'(1);
    assign w_rcnt_inc  = r_rcnt + CW'(1);
    assign w_key_match = (w_result == SCAN_SINGLE) && (w_code == r_cand);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);

    logic [RW-1:0] r_rep;
    logic [RW-1:0] w_rep_inc;

    assign w_rep_inc  = r_rep + RW'(1);
    assign w_rep_fire = (r_state == PRESSED) && w_key_match && (w_rep_inc == RW'(REPEAT_SCANS));

    // Count consecutive same-key scans while held; any other result restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep <= '0;
        end else if (w_scan_done) begin
            if ((r_state == PRESSED) && w_key_match) begin
                r_rep <= w_rep_fire ? '0 : w_rep_inc;
            end else begin
                r_rep <= '0;
            end
        end else begin
            r_rep <= r_rep;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state, evaluated once per completed scan.
    always_comb begin
        w_next_state = r_state;
        if (w_scan_done) begin
            case (r_state)
                IDLE: begin
                    if (w_result == SCAN_SINGLE) begin
                        w_next_state = (CW'(DEBOUNCE_SCANS) == CW'(1)) ? PRESSED : DEBOUNCE;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
                DEBOUNCE: begin
                    if (w_key_match) begin
                        w_next_state = (w_cnt_inc == CW'(DEBOUNCE_SCANS)) ? PRESSED : DEBOUNCE;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
                PRESSED: begin
                    if ((w_result == SCAN_NONE) && (w_rcnt_inc == CW'(DEBOUNCE_SCANS))) begin
                        w_next_state = IDLE;
                    end else begin
                        w_next_state = PRESSED;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end else begin
            w_next_state = r_state;
        end
    end

    // FSM outputs: accept on entry to PRESSED or on an auto-repeat scan.
    always_comb begin
        w_accept      = 1'b0;
        w_accept_code = r_cand;
        if (w_scan_done) begin
            case (r_state)
                IDLE: begin
                    w_accept      = (w_next_state == PRESSED);
                    w_accept_code = w_code;
                end
                DEBOUNCE: w_accept = (w_next_state == PRESSED);
                PRESSED:  w_accept = w_rep_fire;
                default:  w_accept = 1'b0;
            endcase
        end else begin
            w_accept = 1'b0;
        end
    end

    // Debounce/release counters and the candidate key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand <= 4'h0;
            r_cnt  <= '0;
            r_rcnt <= '0;
        end else if (w_scan_done) begin
            case (r_state)
                IDLE: begin
                    r_rcnt <= '0;
                    if (w_result == SCAN_SINGLE) begin
                        r_cand <= w_code;
                        r_cnt  <= CW'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end
                DEBOUNCE: begin
                    r_rcnt <= '0;
                    r_cnt  <= w_key_match ? w_cnt_inc : '0;
                end
                PRESSED: begin
                    r_cnt <= '0;
                    if ((w_result == SCAN_NONE) && (w_next_state == PRESSED)) begin
                        r_rcnt <= w_rcnt_inc;
                    end else begin
                        r_rcnt <= '0;
                    end
                end
                default: begin
                    r_cnt  <= '0;
                    r_rcnt <= '0;
                end
            endcase
        end else begin
            r_cnt  <= r_cnt;
            r_rcnt <= r_rcnt;
        end
    end

    // Registered key outputs and the history shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_data      <= 16'h0000;
        end else begin
            r_key_valid <= w_accept;
            r_key_held  <= (w_next_state == PRESSED);
            if (w_accept) begin
                r_key_code <= w_accept_code;
                r_data     <= {r_data[11:0], w_accept_code};
            end else begin
                r_key_code <= r_key_code;
                r_data     <= r_data;
            end
        end
    end

    assign rows      = w_rows;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign data      = r_data;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed plan plus random key traffic vs. a scan-level model.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;
    localparam int REP      = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  cols_s;
    logic [3:0]  rows_s;
    logic [3:0]  key_code_s;
    logic        key_valid_s;
    logic        key_held_s;
    logic [15:0] data_s;
    logic [15:0] mask_r = 16'h0000;

    int checks_r = 0;
    int fails_r  = 0;
    int strobes_total = 0;
    int s0;
    int exp_rep;

    logic [3:0] map_r [16];

    bit          m_held;
    int          m_run;
    int          m_rc;
    int          m_rep;
    logic [3:0]  m_cand;
    logic [3:0]  m_code;
    logic [15:0] m_data;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB),
        .REPEAT_SCANS   (REP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cols      (cols_s),
        .rows      (rows_s),
        .key_code  (key_code_s),
        .key_valid (key_valid_s),
        .key_held  (key_held_s),
        .data      (data_s)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        cols_s = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (mask_r[r*4+c] && !rows_s[r]) cols_s[c] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            fails_r++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_held = 1'b0; m_run = 0; m_rc = 0; m_rep = 0;
        m_cand = 4'h0; m_code = 4'h0; m_data = 16'h0000;
    endtask

    task automatic model_accept(inout int n);
        m_code = m_cand;
        m_data = {m_data[11:0], m_cand};
        n++;
    endtask

    // One whole scan seen with a constant set of pressed keys.
    task automatic model_scan(input logic [15:0] m, output int exp_p);
        int n;
        logic [3:0] k;
        n = $countones(m);
        k = 4'h0;
        exp_p = 0;
        for (int i = 0; i < 16; i++) if (m[i]) k = map_r[i];
        if (!m_held) begin
            if (m_run == 0) begin
                if (n == 1) begin m_cand = k; m_run = 1; end
            end else if (n == 1 && k == m_cand) begin
                m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run == DEB) begin
                model_accept(exp_p);
                m_held = 1'b1; m_run = 0; m_rc = 0; m_rep = 0;
            end
        end else begin
            if (n == 0) begin
                m_rc++;
                if (m_rc == DEB) begin m_held = 1'b0; m_rc = 0; end
            end else begin
                m_rc = 0;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            if (n == 1 && k == m_cand) begin
                m_rep++;
                if (m_rep == REP) begin model_accept(exp_p); m_rep = 0; end
            end else begin
                m_rep = 0;
            end
`endif
        end
    endtask

    // Apply a key set at a scan boundary and run until the next one.
    task automatic run_scan(input logic [15:0] m, input string tag);
        int pulses;
        int exp_p;
        bit seen3;
        bit done;
        pulses = 0; seen3 = 1'b0; done = 1'b0;
        mask_r = m;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            if (key_valid_s) pulses++;
            if (rows_s == 4'b0111) seen3 = 1'b1;
            else if (seen3 && rows_s == 4'b1110) done = 1'b1;
        end
        if (!done) check_eq({tag, "_scan_timeout"}, 32'd0, 32'd1);
        model_scan(m, exp_p);
        strobes_total += pulses;
        check_eq({tag, "_pulses"}, pulses, exp_p);
        check_eq({tag, "_code"}, {28'd0, key_code_s}, {28'd0, m_code});
        check_eq({tag, "_held"}, {31'd0, key_held_s}, {31'd0, m_held});
        check_eq({tag, "_data"}, {16'd0, data_s}, {16'd0, m_data});
    endtask

    task automatic repeat_scan(input logic [15:0] m, input int n, input string tag);
        for (int i = 0; i < n; i++) run_scan(m, tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_rows"}, {28'd0, rows_s}, 32'h0000_000E);
        check_eq({tag, "_valid"}, {31'd0, key_valid_s}, 32'd0);
        check_eq({tag, "_held"}, {31'd0, key_held_s}, 32'd0);
        check_eq({tag, "_code"}, {28'd0, key_code_s}, 32'd0);
        check_eq({tag, "_data"}, {16'd0, data_s}, 32'd0);
    endtask

    // Async reset a few cycles into a scan, then release on a scan-aligned edge.
    task automatic reset_mid(input string tag);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals(tag);
        @(negedge clk);
        check_eq({tag, "_hold_valid"}, {31'd0, key_valid_s}, 32'd0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [15:0] rm;
        int sel;
        int b0;
        int b1;
        map_r = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                  4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Single key 5 held, then released
        s0 = strobes_total;
        repeat_scan(16'h0020, 10, "k5");
        check_eq("k5_count", strobes_total - s0, 32'd1);
        check_eq("k5_code", {28'd0, key_code_s}, 32'h5);
        check_eq("k5_dataw", {16'd0, data_s}, 32'h0005);
        run_scan(16'h0000, "k5_rel1");
        check_eq("k5_held_rel1", {31'd0, key_held_s}, 32'd1);
        run_scan(16'h0000, "k5_rel2");
        check_eq("k5_held_rel2", {31'd0, key_held_s}, 32'd0);

        // Sequence 1 2 3 A then 7
        repeat_scan(16'h0001, 3, "k1"); repeat_scan(16'h0000, 3, "g1");
        repeat_scan(16'h0002, 3, "k2"); repeat_scan(16'h0000, 3, "g2");
        repeat_scan(16'h0004, 3, "k3"); repeat_scan(16'h0000, 3, "g3");
        repeat_scan(16'h0008, 3, "kA"); repeat_scan(16'h0000, 3, "gA");
        check_eq("seq4_data", {16'd0, data_s}, 32'h123A);
        repeat_scan(16'h0100, 3, "k7"); repeat_scan(16'h0000, 3, "g7");
        check_eq("seq5_data", {16'd0, data_s}, 32'h23A7);

        // Bounce on key 9
        s0 = strobes_total;
        run_scan(16'h0400, "b9a"); run_scan(16'h0000, "b9b"); run_scan(16'h0400, "b9c");
        repeat_scan(16'h0000, 3, "b9g");
        check_eq("bounce_count", strobes_total - s0, 32'd0);
        check_eq("bounce_held", {31'd0, key_held_s}, 32'd0);

        // Ghosting: 1 and 2 together, then 1 alone
        s0 = strobes_total;
        repeat_scan(16'h0003, 10, "multi");
        check_eq("multi_count", strobes_total - s0, 32'd0);
        check_eq("multi_held", {31'd0, key_held_s}, 32'd0);
        repeat_scan(16'h0001, 2, "multi_k1");
        check_eq("multi_k1_count", strobes_total - s0, 32'd1);
        check_eq("multi_k1_code", {28'd0, key_code_s}, 32'h1);
        repeat_scan(16'h0000, 3, "multi_g");

        // Long hold of key 0
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_rep = 7;
`else
        exp_rep = 1;
`endif
        s0 = strobes_total;
        repeat_scan(16'h2000, 100, "k0");
        check_eq("k0_count", strobes_total - s0, exp_rep);
        check_eq("k0_code", {28'd0, key_code_s}, 32'h0);
        repeat_scan(16'h0000, 3, "k0_g");

        // Reset during DEBOUNCE and during PRESSED
        run_scan(16'h0400, "rd_k9");
        reset_mid("rst_deb");
        s0 = strobes_total;
        repeat_scan(16'h0400, DEB, "rd_reacc");
        check_eq("rd_reacc_count", strobes_total - s0, 32'd1);
        check_eq("rd_reacc_data", {16'd0, data_s}, 32'h0009);
        run_scan(16'h0400, "rp_k9");
        reset_mid("rst_prs");
        s0 = strobes_total;
        repeat_scan(16'h0400, DEB, "rp_reacc");
        check_eq("rp_reacc_count", strobes_total - s0, 32'd1);
        check_eq("rp_reacc_held", {31'd0, key_held_s}, 32'd1);
        repeat_scan(16'h0000, 3, "rp_g");

        // Random traffic: idle, single keys and occasional key pairs
        for (int seg = 0; seg < 40; seg++) begin
            sel = $urandom_range(0, 9);
            b0 = $urandom_range(0, 15);
            b1 = $urandom_range(0, 15);
            rm = 16'h0000;
            if (sel >= 3) rm[b0] = 1'b1;
            if (sel == 9) rm[b1] = 1'b1;
            repeat_scan(rm, $urandom_range(1, 4), "rnd");
        end
        repeat_scan(16'h0000, 3, "rnd_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, fails_r);
        $finish;
    end

endmodule
